// File: rtl/mc_core.sv
// mc_core: multi-cycle processor core for the 16-bit instruction set, sequenced as
// FETCH/DECODE/EXEC/MEM/WB over handshaked instruction and data memory ports.
module mc_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              ovf,
  output logic              retire,
  output logic              halted
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t state_r, state_nx_s;

  logic imem_req_r, imem_req_nx_s;
  logic dmem_req_r, dmem_req_nx_s;
  logic retire_r, retire_nx_s;
  logic halted_r, halted_nx_s;
  logic dmem_we_r;
  logic [DATA_W-1:0] dmem_addr_r;
  logic [DATA_W-1:0] dmem_wdata_r;

  logic [15:0]       instr_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] res_r;
  logic              carry_r;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   pc_nx_r;
  logic              ovf_r;
  logic [DATA_W-1:0] regs_r [0:3];

  logic [3:0]        op_s;
  logic [1:0]        rs_s;
  logic [1:0]        rt_s;
  logic [1:0]        rd_s;
  logic [7:0]        imm_s;
  logic signed [7:0] imm_sg_s;
  logic [DATA_W-1:0] sext_d_s;
  logic [PC_W-1:0]   sext_p_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic [PC_W-1:0]   pc_next_s;
  logic [DATA_W-1:0] alu_s;
  logic              carry_s;
  logic [DATA_W-1:0] ea_s;
  logic              is_mem_s;
  logic              fetch_done_s;
  logic              mem_done_s;

  assign op_s     = instr_r[15:12];
  assign rs_s     = instr_r[11:10];
  assign rt_s     = instr_r[9:8];
  assign rd_s     = instr_r[7:6];
  assign imm_s    = instr_r[7:0];
  assign imm_sg_s = imm_s;
  // Signed casts sign-extend when widening and truncate when PC_W is narrower than 8.
  assign sext_d_s = DATA_W'(imm_sg_s);
  assign sext_p_s = PC_W'(imm_sg_s);
  assign pc_inc_s = pc_r + PC_W'(1'b1);
  assign ea_s     = a_r + sext_d_s;
  assign is_mem_s = (op_s == OP_LW) || (op_s == OP_SW);

  // A transfer completes only on a cycle where our own request is high.
  assign fetch_done_s = imem_req_r && imem_ack;
  assign mem_done_s   = dmem_req_r && dmem_ack;

  // ALU result and carry/borrow for the instruction held in EXEC
  always_comb begin
    alu_s   = '0;
    carry_s = 1'b0;
    case (op_s)
      OP_ADD:  {carry_s, alu_s} = {1'b0, a_r} + {1'b0, b_r};
      OP_SUB:  {carry_s, alu_s} = {1'b0, a_r} - {1'b0, b_r};
      OP_AND:  alu_s = a_r & b_r;
      OP_OR:   alu_s = a_r | b_r;
      OP_ADDI: {carry_s, alu_s} = {1'b0, a_r} + {1'b0, sext_d_s};
      default: alu_s = '0;
    endcase
  end

  // Next program counter: branch, jump or fall-through
  always_comb begin
    pc_next_s = pc_inc_s;
    if (op_s == OP_BEQ) begin
      if (a_r == b_r) begin
        pc_next_s = pc_inc_s + sext_p_s;
      end else begin
        pc_next_s = pc_inc_s;
      end
    end else if (op_s == OP_JMP) begin
      pc_next_s = PC_W'(imm_s);
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // Sequencer next state and next values of the registered control outputs
  always_comb begin
    state_nx_s    = state_r;
    imem_req_nx_s = 1'b0;
    dmem_req_nx_s = 1'b0;
    retire_nx_s   = 1'b0;
    halted_nx_s   = halted_r;
    case (state_r)
      ST_FETCH: begin
        if (fetch_done_s) begin
          state_nx_s = ST_DECODE;
        end else begin
          imem_req_nx_s = 1'b1;
        end
      end
      ST_DECODE: state_nx_s = ST_EXEC;
      ST_EXEC: begin
        if (is_mem_s) begin
          state_nx_s    = ST_MEM;
          dmem_req_nx_s = 1'b1;
        end else if (op_s == OP_HALT) begin
          state_nx_s  = ST_HALT;
          halted_nx_s = 1'b1;
        end else begin
          state_nx_s  = ST_WB;
          retire_nx_s = 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_done_s) begin
          state_nx_s  = ST_WB;
          retire_nx_s = 1'b1;
        end else begin
          dmem_req_nx_s = 1'b1;
        end
      end
      ST_WB: begin
        state_nx_s    = ST_FETCH;
        imem_req_nx_s = 1'b1;
      end
      ST_HALT: state_nx_s = ST_HALT;
      default: state_nx_s = ST_FETCH;
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_FETCH;
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      retire_r   <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      imem_req_r <= imem_req_nx_s;
      dmem_req_r <= dmem_req_nx_s;
      retire_r   <= retire_nx_s;
      halted_r   <= halted_nx_s;
    end
  end

  // Datapath: instruction latch, operands, results, memory access fields, pc and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_r      <= 16'h0000;
      a_r          <= '0;
      b_r          <= '0;
      res_r        <= '0;
      carry_r      <= 1'b0;
      pc_r         <= '0;
      pc_nx_r      <= '0;
      ovf_r        <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= '0;
      dmem_wdata_r <= '0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (fetch_done_s) begin
            instr_r <= imem_rdata;
          end
        end
        ST_DECODE: begin
          a_r <= regs_r[rs_s];
          b_r <= regs_r[rt_s];
        end
        ST_EXEC: begin
          res_r   <= alu_s;
          carry_r <= carry_s;
          pc_nx_r <= pc_next_s;
          // Address, data and direction are frozen here for the whole MEM phase.
          if (is_mem_s) begin
            dmem_addr_r  <= ea_s;
            dmem_wdata_r <= b_r;
            dmem_we_r    <= (op_s == OP_SW);
          end
        end
        ST_MEM: begin
          if (mem_done_s) begin
            if (!dmem_we_r) begin
              res_r <= dmem_rdata;
            end
            dmem_we_r <= 1'b0;
          end
        end
        ST_WB: begin
          pc_r  <= pc_nx_r;
          ovf_r <= ovf_r | carry_r;
        end
        default: ;
      endcase
    end
  end

  // Register file: written only in WB by ALU, ADDI and LW
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= '0;
      end
    end else if (state_r == ST_WB) begin
      case (op_s)
        OP_ADD, OP_SUB, OP_AND, OP_OR: regs_r[rd_s] <= res_r;
        OP_ADDI, OP_LW:                regs_r[rt_s] <= res_r;
        default: ;
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wdata = dmem_wdata_r;
  assign pc         = pc_r;
  assign ovf        = ovf_r;
  assign retire     = retire_r;
  assign halted     = halted_r;

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: default 8/8 instance with wait-state memory models,
// plus a DATA_W=16 / PC_W=4 instance for width-dependent behaviour.
module tb_mc_core;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       imem_req, imem_ack;
  logic [7:0] imem_addr;
  logic [15:0] imem_rdata;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0] pc;
  logic       ovf, retire, halted;

  logic        b_imem_req, b_imem_ack;
  logic [3:0]  b_imem_addr;
  logic [15:0] b_imem_rdata;
  logic        b_dmem_req, b_dmem_we, b_dmem_ack;
  logic [15:0] b_dmem_addr, b_dmem_wdata, b_dmem_rdata;
  logic [3:0]  b_pc;
  logic        b_ovf, b_retire, b_halted;

  mc_core #(.DATA_W(8), .PC_W(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .ovf(ovf), .retire(retire), .halted(halted)
  );

  mc_core #(.DATA_W(16), .PC_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata),
    .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
    .dmem_ack(b_dmem_ack), .dmem_rdata(b_dmem_rdata),
    .pc(b_pc), .ovf(b_ovf), .retire(b_retire), .halted(b_halted)
  );

  int total = 0;
  int bad = 0;

  logic [15:0] prog [256];
  logic [7:0]  dmem [256];
  logic [15:0] progb [16];
  int imem_delay = 0;
  int dmem_delay = 0;
  int flog[$];
  int blog[$];

  int t_first, t_halt, run_len, unstable;
  int ret_t[$];
  int r_len[$];
  logic [7:0] r_addr[$];
  logic [7:0] r_wd[$];
  logic       r_we[$];
  logic       ovf_log[$];

  initial forever #5 clk = ~clk;

  // Memory models for the 8/8 core: respond on the falling edge, wait states per port.
  initial begin
    int icnt, dcnt;
    icnt = 0; dcnt = 0;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0000; dmem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        imem_ack = 1'b0; dmem_ack = 1'b0; icnt = 0; dcnt = 0;
      end else begin
        if (imem_req) begin
          if (icnt == imem_delay) begin
            imem_ack = 1'b1; imem_rdata = prog[imem_addr]; flog.push_back(int'(imem_addr)); icnt = 0;
          end else begin
            imem_ack = 1'b0; icnt++;
          end
        end else begin
          imem_ack = 1'b0; icnt = 0;
        end
        if (dmem_req) begin
          if (dcnt == dmem_delay) begin
            dmem_ack = 1'b1; dcnt = 0;
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            else dmem_rdata = dmem[dmem_addr];
          end else begin
            dmem_ack = 1'b0; dcnt++;
          end
        end else begin
          dmem_ack = 1'b0; dcnt = 0;
        end
      end
    end
  end

  // Zero-wait memory model for the 16/4 core.
  initial begin
    b_imem_ack = 1'b0; b_dmem_ack = 1'b0; b_imem_rdata = 16'h0000; b_dmem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        b_imem_ack = 1'b0; b_dmem_ack = 1'b0;
      end else begin
        b_imem_ack = b_imem_req;
        b_imem_rdata = progb[b_imem_addr];
        if (b_imem_req) blog.push_back(int'(b_imem_addr));
        b_dmem_ack = b_dmem_req;
      end
    end
  end

  function automatic logic [15:0] ii(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt, input logic [7:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd);
    return {op, rs, rt, rd, 6'b000000};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h9000;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic run(input int max, input bit want_halt);
    logic prev_req, prev_ret, p_we;
    logic [7:0] p_addr, p_wd;
    t_first = -1; t_halt = -1; run_len = 0; unstable = 0;
    prev_req = 1'b0; prev_ret = 1'b0; p_we = 1'b0; p_addr = 8'h00; p_wd = 8'h00;
    ret_t.delete(); r_len.delete(); r_addr.delete(); r_wd.delete(); r_we.delete(); ovf_log.delete();
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (prev_ret) ovf_log.push_back(ovf);
      prev_ret = retire;
      if (t_first < 0 && imem_req) t_first = i;
      if (retire) ret_t.push_back(i);
      if (dmem_req) begin
        if (!prev_req) begin
          r_addr.push_back(dmem_addr); r_we.push_back(dmem_we); r_wd.push_back(dmem_wdata);
        end else if (dmem_addr !== p_addr || dmem_we !== p_we || dmem_wdata !== p_wd) begin
          unstable++;
        end
        run_len++; p_addr = dmem_addr; p_we = dmem_we; p_wd = dmem_wdata;
      end else if (run_len > 0) begin
        r_len.push_back(run_len); run_len = 0;
      end
      prev_req = dmem_req;
      if (halted && t_halt < 0) begin
        t_halt = i;
        if (want_halt) break;
      end
    end
    if (want_halt && t_halt < 0) begin
      total++; bad++; $display("FAIL run_timeout: halted=%0b expected 1", halted);
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if ({imem_req, dmem_req, dmem_we, retire, halted, ovf} !== 6'b000000) begin bad++; $display("FAIL reset_ctrl: got %b expected 000000", {imem_req, dmem_req, dmem_we, retire, halted, ovf}); end
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    @(posedge clk); #2;
    rst = 1'b1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req_before_edge: got %b expected 0", imem_req); end
    @(posedge clk); #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL reset_first_fetch: req=%b addr=%0h expected req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_basic();
    clear_prog();
    prog[0] = ii(4'h4, 2'd0, 2'd1, 8'h05);
    prog[1] = ii(4'h4, 2'd0, 2'd2, 8'h03);
    prog[2] = rr(4'h0, 2'd1, 2'd2, 2'd3);
    do_reset();
    run(100, 1'b1);
    total++; if (t_halt - t_first !== 15) begin bad++; $display("FAIL basic_cycles: got %0d expected 15", t_halt - t_first); end
    total++; if (ret_t.size() !== 3) begin bad++; $display("FAIL basic_retires: got %0d expected 3", ret_t.size()); end
    total++; if (dut.regs_r[3] !== 8'h08) begin bad++; $display("FAIL basic_r3: got %0h expected 8", dut.regs_r[3]); end
    total++; if (pc !== 8'h03) begin bad++; $display("FAIL basic_pc: got %0h expected 3", pc); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
    repeat (3) @(posedge clk); #1;
    total++; if ({halted, imem_req, dmem_req, retire} !== 4'b1000 || pc !== 8'h03) begin bad++; $display("FAIL halt_hold: got h/ireq/dreq/ret=%b pc=%0h expected 1000 pc=3", {halted, imem_req, dmem_req, retire}, pc); end
  endtask

  task automatic test_imem_wait();
    clear_prog();
    prog[0] = ii(4'h4, 2'd0, 2'd1, 8'h07);
    imem_delay = 2;
    do_reset();
    run(100, 1'b1);
    imem_delay = 0;
    total++; if (t_halt - t_first !== 11) begin bad++; $display("FAIL imem_wait_cycles: got %0d expected 11", t_halt - t_first); end
    total++; if (dut.regs_r[1] !== 8'h07) begin bad++; $display("FAIL imem_wait_r1: got %0h expected 7", dut.regs_r[1]); end
  endtask

  task automatic test_ovf_sticky();
    clear_prog();
    prog[0] = ii(4'h4, 2'd0, 2'd1, 8'hFF);
    prog[1] = ii(4'h4, 2'd1, 2'd1, 8'h01);
    prog[2] = ii(4'h4, 2'd0, 2'd2, 8'h05);
    prog[3] = ii(4'h4, 2'd0, 2'd3, 8'h03);
    prog[4] = rr(4'h1, 2'd2, 2'd3, 2'd2);
    prog[5] = ii(4'h6, 2'd0, 2'd2, 8'h40);
    prog[6] = ii(4'h6, 2'd0, 2'd1, 8'h41);
    do_reset();
    run(200, 1'b1);
    total++; if (ovf_log.size() !== 7) begin bad++; $display("FAIL ovf_log_len: got %0d expected 7", ovf_log.size()); end
    else begin
      total++; if (ovf_log[0] !== 1'b0) begin bad++; $display("FAIL ovf_after_addi_ff: got %b expected 0", ovf_log[0]); end
      total++; if (ovf_log[1] !== 1'b1) begin bad++; $display("FAIL ovf_after_carry: got %b expected 1", ovf_log[1]); end
      total++; if (ovf_log[4] !== 1'b1) begin bad++; $display("FAIL ovf_sticky_sub: got %b expected 1", ovf_log[4]); end
    end
    total++; if (dmem[8'h40] !== 8'h02) begin bad++; $display("FAIL sub_result: got %0h expected 2", dmem[8'h40]); end
    total++; if (dmem[8'h41] !== 8'h00) begin bad++; $display("FAIL wrap_result: got %0h expected 0", dmem[8'h41]); end
  endtask

  task automatic test_logic_borrow();
    clear_prog();
    prog[0] = ii(4'h4, 2'd0, 2'd1, 8'h03);
    prog[1] = ii(4'h4, 2'd0, 2'd2, 8'h05);
    prog[2] = rr(4'h2, 2'd1, 2'd2, 2'd3);
    prog[3] = ii(4'h6, 2'd0, 2'd3, 8'h43);
    prog[4] = rr(4'h3, 2'd1, 2'd2, 2'd3);
    prog[5] = ii(4'h6, 2'd0, 2'd3, 8'h44);
    prog[6] = rr(4'h1, 2'd1, 2'd2, 2'd3);
    prog[7] = ii(4'h6, 2'd0, 2'd3, 8'h42);
    do_reset();
    run(200, 1'b1);
    total++; if (dmem[8'h43] !== 8'h01) begin bad++; $display("FAIL and_result: got %0h expected 1", dmem[8'h43]); end
    total++; if (dmem[8'h44] !== 8'h07) begin bad++; $display("FAIL or_result: got %0h expected 7", dmem[8'h44]); end
    total++; if (dmem[8'h42] !== 8'hFE) begin bad++; $display("FAIL borrow_result: got %0h expected fe", dmem[8'h42]); end
    total++; if (ovf_log.size() < 7 || ovf_log[5] !== 1'b0 || ovf_log[6] !== 1'b1) begin bad++; $display("FAIL borrow_ovf: log_len=%0d expected ovf 0 before SUB and 1 after", ovf_log.size()); end
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp_addr [3];
    logic       exp_we [3];
    exp_addr[0] = 8'h10; exp_addr[1] = 8'h10; exp_addr[2] = 8'h11;
    exp_we[0] = 1'b1; exp_we[1] = 1'b0; exp_we[2] = 1'b1;
    clear_prog();
    prog[0] = ii(4'h4, 2'd0, 2'd1, 8'hA5);
    prog[1] = ii(4'h6, 2'd0, 2'd1, 8'h10);
    prog[2] = ii(4'h5, 2'd0, 2'd2, 8'h10);
    prog[3] = ii(4'h6, 2'd0, 2'd2, 8'h11);
    dmem_delay = 3;
    do_reset();
    run(200, 1'b1);
    dmem_delay = 0;
    total++; if (ret_t.size() !== 4) begin bad++; $display("FAIL mem_retires: got %0d expected 4", ret_t.size()); end
    else begin
      total++; if (ret_t[1] - ret_t[0] !== 8 || ret_t[2] - ret_t[1] !== 8 || ret_t[3] - ret_t[2] !== 8) begin bad++; $display("FAIL mem_instr_cycles: got %0d %0d %0d expected 8 8 8", ret_t[1] - ret_t[0], ret_t[2] - ret_t[1], ret_t[3] - ret_t[2]); end
    end
    total++; if (r_len.size() !== 3) begin bad++; $display("FAIL mem_req_count: got %0d expected 3", r_len.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        total++; if (r_len[k] !== 4 || r_addr[k] !== exp_addr[k] || r_we[k] !== exp_we[k]) begin bad++; $display("FAIL mem_req_%0d: len=%0d addr=%0h we=%b expected len=4 addr=%0h we=%b", k, r_len[k], r_addr[k], r_we[k], exp_addr[k], exp_we[k]); end
      end
      total++; if (r_wd[0] !== 8'hA5) begin bad++; $display("FAIL store_wdata: got %0h expected a5", r_wd[0]); end
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL mem_stable: got %0d changes expected 0", unstable); end
    total++; if (dut.regs_r[2] !== 8'hA5 || dmem[8'h11] !== 8'hA5) begin bad++; $display("FAIL load_data: r2=%0h mem11=%0h expected a5 a5", dut.regs_r[2], dmem[8'h11]); end
    total++; if (t_halt - t_first !== 31) begin bad++; $display("FAIL mem_total_cycles: got %0d expected 31", t_halt - t_first); end
  endtask

  task automatic test_branch();
    int fbase;
    int exp_f [7];
    exp_f[0] = 0; exp_f[1] = 1; exp_f[2] = 4; exp_f[3] = 5; exp_f[4] = 32; exp_f[5] = 32; exp_f[6] = 32;
    clear_prog();
    prog[0]     = ii(4'h4, 2'd0, 2'd1, 8'h01);
    prog[1]     = ii(4'h8, 2'd0, 2'd0, 8'h04);
    prog[4]     = ii(4'h7, 2'd1, 2'd0, 8'hFF);
    prog[5]     = ii(4'h8, 2'd0, 2'd0, 8'h20);
    prog[8'h20] = ii(4'h7, 2'd0, 2'd0, 8'hFF);
    do_reset();
    fbase = flog.size();
    run(40, 1'b0);
    total++; if (flog.size() - fbase < 7) begin bad++; $display("FAIL branch_fetch_count: got %0d expected >=7", flog.size() - fbase); end
    else begin
      for (int k = 0; k < 7; k++) begin
        total++; if (flog[fbase + k] !== exp_f[k]) begin bad++; $display("FAIL branch_fetch_%0d: got %0h expected %0h", k, flog[fbase + k], exp_f[k]); end
      end
    end
    total++; if (halted !== 1'b0 || imem_addr !== 8'h20) begin bad++; $display("FAIL branch_loop: halted=%b addr=%0h expected 0 20", halted, imem_addr); end
  endtask

  task automatic test_reset_mid_mem();
    int fbase;
    bit seen;
    clear_prog();
    prog[0] = ii(4'h4, 2'd0, 2'd1, 8'h55);
    prog[1] = ii(4'h6, 2'd0, 2'd1, 8'h12);
    dmem_delay = 20;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (dmem_req) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL midmem_req_seen: got 0 expected 1"); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin bad++; $display("FAIL midmem_req_drop: req=%b we=%b expected 0 0", dmem_req, dmem_we); end
    @(posedge clk); #1;
    total++; if ({imem_req, dmem_req, retire, halted, ovf} !== 5'b00000 || pc !== 8'h00) begin bad++; $display("FAIL midmem_hold: ctrl=%b pc=%0h expected 00000 0", {imem_req, dmem_req, retire, halted, ovf}, pc); end
    total++; if (dmem[8'h12] === 8'h55) begin bad++; $display("FAIL midmem_abandon: got %0h expected unwritten", dmem[8'h12]); end
    dmem_delay = 0;
    @(posedge clk); #3;
    rst = 1'b1;
    fbase = flog.size();
    run(100, 1'b1);
    total++; if (flog.size() <= fbase || flog[fbase] !== 0) begin bad++; $display("FAIL midmem_refetch: size=%0d first=%0h expected first 0", flog.size() - fbase, (flog.size() > fbase) ? flog[fbase] : -1); end
    total++; if (dmem[8'h12] !== 8'h55) begin bad++; $display("FAIL midmem_rerun_store: got %0h expected 55", dmem[8'h12]); end
  endtask

  task automatic test_params();
    int bbase, nret;
    int exp_b [4];
    exp_b[0] = 0; exp_b[1] = 1; exp_b[2] = 15; exp_b[3] = 0;
    do_reset();
    bbase = blog.size();
    nret = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (b_retire) nret++;
    end
    total++; if (blog.size() - bbase < 4) begin bad++; $display("FAIL wide_fetch_count: got %0d expected >=4", blog.size() - bbase); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++; if (blog[bbase + k] !== exp_b[k]) begin bad++; $display("FAIL wide_fetch_%0d: got %0h expected %0h", k, blog[bbase + k], exp_b[k]); end
      end
    end
    total++; if (dut_b.regs_r[1] !== 16'hFF80) begin bad++; $display("FAIL wide_sext: got %0h expected ff80", dut_b.regs_r[1]); end
    total++; if (nret !== 3) begin bad++; $display("FAIL wide_retires: got %0d expected 3", nret); end
    total++; if (b_imem_addr !== 4'h0 || b_pc !== 4'h0 || b_ovf !== 1'b0 || b_halted !== 1'b0) begin bad++; $display("FAIL wide_state: addr=%0h pc=%0h ovf=%b halted=%b expected 0 0 0 0", b_imem_addr, b_pc, b_ovf, b_halted); end
    total++; if ({b_dmem_req, b_dmem_we, b_dmem_addr, b_dmem_wdata} !== 34'h0) begin bad++; $display("FAIL wide_dmem_idle: got %0h expected 0", {b_dmem_req, b_dmem_we, b_dmem_addr, b_dmem_wdata}); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) progb[i] = 16'hA000;
    progb[0] = ii(4'h4, 2'd0, 2'd1, 8'h80);
    progb[1] = ii(4'h8, 2'd0, 2'd0, 8'h1F);
    clear_prog();
    test_reset();
    test_basic();
    test_imem_wait();
    test_ovf_sticky();
    test_logic_borrow();
    test_mem_wait();
    test_branch();
    test_reset_mid_mem();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
